// File: rtl/puf_challenge_scheduler.sv
// Batch sequencer for the FPGA_PUF kernel: presents trigger/offset per challenge,
// holds them for a settle window, pulses start and waits (timeout-guarded) for done.
module puf_challenge_scheduler #(
  parameter int C_ADDR_WIDTH     = 64,
  parameter int C_COUNT_WIDTH    = 16,
  parameter int C_SETTLE_CYCLES  = 16,
  parameter int C_TIMEOUT_CYCLES = 65535
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [31:0]              cmd_base_trig,
  input  logic [C_COUNT_WIDTH-1:0] cmd_count,
  input  logic [C_ADDR_WIDTH-1:0]  cmd_base_addr,
  input  logic [31:0]              cmd_addr_stride,
  output logic [31:0]              puf_trig,
  output logic [C_ADDR_WIDTH-1:0]  puf_addr_offset,
  output logic                     puf_start,
  input  logic                     puf_done,
  output logic                     busy,
  output logic                     batch_done,
  output logic                     batch_timeout,
  output logic [C_COUNT_WIDTH-1:0] batch_completed
);

  localparam int TW = $clog2(C_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t                   state_r;
  state_t                   state_s;
  logic [7:0]               settle_cnt_r;
  logic [TW-1:0]            timeout_cnt_r;
  logic [C_COUNT_WIDTH-1:0] count_r;
  logic [31:0]              stride_r;
  logic [C_COUNT_WIDTH-1:0] completed_inc_s;

  // Next-state decode; done takes priority over timeout expiry in WAIT
  always_comb begin
    state_s         = state_r;
    completed_inc_s = batch_completed + C_COUNT_WIDTH'(1);
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_count == {C_COUNT_WIDTH{1'b0}}) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SETTLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_r == 8'd1) begin
          state_s = ST_START;
        end else begin
          state_s = ST_SETTLE;
        end
      end
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (puf_done) begin
          if (completed_inc_s == count_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_NEXT;
          end
        end else if (timeout_cnt_r == {TW{1'b0}}) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_NEXT: state_s = ST_SETTLE;
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, datapath and registered outputs (strobes decoded from the next state)
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_r         <= ST_IDLE;
      settle_cnt_r    <= 8'd0;
      timeout_cnt_r   <= {TW{1'b0}};
      count_r         <= {C_COUNT_WIDTH{1'b0}};
      stride_r        <= 32'd0;
      cmd_ready       <= 1'b1;
      busy            <= 1'b0;
      puf_start       <= 1'b0;
      batch_done      <= 1'b0;
      batch_timeout   <= 1'b0;
      batch_completed <= {C_COUNT_WIDTH{1'b0}};
      puf_trig        <= 32'd0;
      puf_addr_offset <= {C_ADDR_WIDTH{1'b0}};
    end else begin
      state_r    <= state_s;
      cmd_ready  <= (state_s == ST_IDLE);
      busy       <= (state_s != ST_IDLE);
      puf_start  <= (state_s == ST_START);
      batch_done <= (state_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            count_r         <= cmd_count;
            stride_r        <= cmd_addr_stride;
            puf_trig        <= cmd_base_trig;
            puf_addr_offset <= cmd_base_addr;
            batch_completed <= {C_COUNT_WIDTH{1'b0}};
            batch_timeout   <= 1'b0;
            settle_cnt_r    <= 8'(C_SETTLE_CYCLES);
          end
        end
        ST_SETTLE: settle_cnt_r <= settle_cnt_r - 8'd1;
        ST_START:  timeout_cnt_r <= TW'(C_TIMEOUT_CYCLES);
        ST_WAIT: begin
          if (puf_done) begin
            // saturate at the latched count
            if (batch_completed != count_r) begin
              batch_completed <= completed_inc_s;
            end
          end else if (timeout_cnt_r == {TW{1'b0}}) begin
            batch_timeout <= 1'b1;
          end else begin
            timeout_cnt_r <= timeout_cnt_r - TW'(1);
          end
        end
        ST_NEXT: begin
          puf_trig        <= puf_trig + 32'd1;
          puf_addr_offset <= puf_addr_offset + C_ADDR_WIDTH'(stride_r);
          settle_cnt_r    <= 8'(C_SETTLE_CYCLES);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_scheduler.sv
// Self-checking bench: predicts start/done timing and trig/offset sequence for each
// batch from the behavioural rules, with a scripted kernel that answers each start.
module tb_puf_challenge_scheduler;
  localparam int S  = 4;
  localparam int T  = 8;
  localparam int AW = 64;
  localparam int CW = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [31:0]   cmd_base_trig;
  logic [CW-1:0] cmd_count;
  logic [AW-1:0] cmd_base_addr;
  logic [31:0]   cmd_addr_stride;
  logic [31:0]   puf_trig;
  logic [AW-1:0] puf_addr_offset;
  logic          puf_start;
  logic          puf_done;
  logic          busy;
  logic          batch_done;
  logic          batch_timeout;
  logic [CW-1:0] batch_completed;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  puf_challenge_scheduler #(
    .C_ADDR_WIDTH(AW), .C_COUNT_WIDTH(CW),
    .C_SETTLE_CYCLES(S), .C_TIMEOUT_CYCLES(T)
  ) dut (
    .aclk(aclk), .areset(areset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_trig(cmd_base_trig), .cmd_count(cmd_count),
    .cmd_base_addr(cmd_base_addr), .cmd_addr_stride(cmd_addr_stride),
    .puf_trig(puf_trig), .puf_addr_offset(puf_addr_offset),
    .puf_start(puf_start), .puf_done(puf_done), .busy(busy),
    .batch_done(batch_done), .batch_timeout(batch_timeout),
    .batch_completed(batch_completed)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit in_q(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive_idle();
    cmd_valid       = 1'b0;
    cmd_base_trig   = 32'd0;
    cmd_count       = 16'd0;
    cmd_base_addr   = 64'd0;
    cmd_addr_stride = 32'd0;
    puf_done        = 1'b0;
  endtask

  // One batch: model predicts schedule, kernel answers each start after dly[i] cycles
  task automatic run_batch(input logic [31:0] base_trig, input int count,
                           input logic [63:0] base_addr, input logic [31:0] stride,
                           input int dly[$], input bit spur);
    int e, bd, p, compl, n_bd, bd_obs, busy_bad;
    bit to;
    bit exp_busy;
    int exp_cyc[$];
    logic [31:0] exp_trig[$];
    logic [63:0] exp_addr[$];
    int done_at[$];
    int spur_at[$];
    int obs_cyc[$];
    logic [31:0] obs_trig[$];
    logic [63:0] obs_addr[$];
    logic [31:0] last_trig;
    logic [63:0] last_addr;
    @(negedge aclk);
    e = cyc;
    compl = 0; to = 1'b0; n_bd = 0; bd_obs = -1; busy_bad = 0; bd = e + 1;
    if (count > 0) begin
      p = e + 1 + S;
      for (int i = 0; i < count; i++) begin
        exp_cyc.push_back(p);
        exp_trig.push_back(base_trig + 32'(i));
        exp_addr.push_back(base_addr + 64'(i) * 64'(stride));
        spur_at.push_back(p - 2);
        spur_at.push_back(p);
        if (dly[i] <= T + 1) begin
          done_at.push_back(p + dly[i]);
          compl++;
          if (i == count - 1) bd = p + dly[i] + 1;
          else p = p + dly[i] + 2 + S;
        end else begin
          to = 1'b1;
          bd = p + T + 2;
          break;
        end
      end
    end
    last_trig = (exp_trig.size() > 0) ? exp_trig[exp_trig.size()-1] : base_trig;
    last_addr = (exp_addr.size() > 0) ? exp_addr[exp_addr.size()-1] : base_addr;

    for (int n = e; n <= bd + 2; n++) begin
      if (n != e) @(negedge aclk);
      exp_busy = (n >= e + 1) && (n <= bd);
      if (busy !== exp_busy || cmd_ready !== !exp_busy) busy_bad++;
      if (puf_start === 1'b1) begin
        obs_cyc.push_back(n);
        obs_trig.push_back(puf_trig);
        obs_addr.push_back(puf_addr_offset);
      end
      if (batch_done === 1'b1) begin
        n_bd++;
        bd_obs = n;
      end
      if (n == e + 1) begin
        chk("accept_clears_timeout", 64'(batch_timeout), 64'd0);
        chk("accept_clears_completed", 64'(batch_completed), 64'd0);
      end
      if (n == e) begin
        cmd_valid       = 1'b1;
        cmd_base_trig   = base_trig;
        cmd_count       = 16'(count);
        cmd_base_addr   = base_addr;
        cmd_addr_stride = stride;
      end else begin
        cmd_valid       = spur && n < bd && ($urandom_range(0, 2) == 0);
        cmd_base_trig   = $urandom;
        cmd_count       = 16'($urandom_range(1, 5));
        cmd_base_addr   = {$urandom, $urandom};
        cmd_addr_stride = $urandom;
      end
      puf_done = in_q(done_at, n) || (spur && in_q(spur_at, n) && ($urandom_range(0, 1) == 1));
    end
    drive_idle();

    chk("start_count", 64'(obs_cyc.size()), 64'(exp_cyc.size()));
    for (int i = 0; i < exp_cyc.size() && i < obs_cyc.size(); i++) begin
      chk($sformatf("start_cycle[%0d]", i), 64'(obs_cyc[i] - e), 64'(exp_cyc[i] - e));
      chk($sformatf("start_trig[%0d]", i), 64'(obs_trig[i]), 64'(exp_trig[i]));
      chk($sformatf("start_addr[%0d]", i), obs_addr[i], exp_addr[i]);
    end
    chk("batch_done_pulses", 64'(n_bd), 64'd1);
    chk("batch_done_cycle", 64'(bd_obs - e), 64'(bd - e));
    chk("busy_ready_profile", 64'(busy_bad), 64'd0);
    chk("batch_completed", 64'(batch_completed), 64'(compl));
    chk("batch_timeout", 64'(batch_timeout), 64'(to));
    chk("trig_hold", 64'(puf_trig), 64'(last_trig));
    chk("addr_hold", puf_addr_offset, last_addr);
  endtask

  initial begin
    int dq[$];
    int cnt;
    int n_st, n_bdp, n_busy;
    drive_idle();
    areset = 1'b1;
    repeat (3) @(negedge aclk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(puf_start), 64'd0);
    chk("rst_batch_done", 64'(batch_done), 64'd0);
    chk("rst_timeout", 64'(batch_timeout), 64'd0);
    chk("rst_trig", 64'(puf_trig), 64'd0);
    chk("rst_addr", puf_addr_offset, 64'd0);
    chk("rst_completed", 64'(batch_completed), 64'd0);
    areset = 1'b0;

    // nominal, zero count, timeout, wrap with done on the final timeout cycle
    dq = '{5, 5, 5};
    run_batch(32'h10, 3, 64'h1000, 32'h40, dq, 1'b0);
    dq = '{};
    run_batch(32'h77, 0, 64'h2000, 32'h8, dq, 1'b0);
    dq = '{5, 100, 5, 5};
    run_batch(32'h20, 4, 64'h4000, 32'h10, dq, 1'b0);
    dq = '{3, T + 1};
    run_batch(32'hFFFF_FFFF, 2, 64'hFFFF_FFFF_FFFF_FFC0, 32'h40, dq, 1'b0);

    for (int b = 0; b < 8; b++) begin
      cnt = $urandom_range(0, 5);
      dq = '{};
      for (int i = 0; i < cnt; i++)
        dq.push_back(($urandom_range(0, 7) == 0) ? 40 : int'($urandom_range(1, T + 1)));
      run_batch($urandom, cnt, {$urandom, $urandom}, $urandom, dq, 1'b1);
    end

    // reset while in WAIT, then a stale done must not restart anything
    @(negedge aclk);
    cmd_valid = 1'b1; cmd_count = 16'd3; cmd_base_trig = 32'h55;
    cmd_base_addr = 64'h100; cmd_addr_stride = 32'h4;
    @(negedge aclk);
    drive_idle();
    repeat (S + 2) @(negedge aclk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(cmd_ready), 64'd1);
    chk("midrst_trig", 64'(puf_trig), 64'd0);
    chk("midrst_completed", 64'(batch_completed), 64'd0);
    puf_done = 1'b1;
    n_st = 0; n_bdp = 0; n_busy = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge aclk);
      puf_done = 1'b0;
      if (puf_start === 1'b1) n_st++;
      if (batch_done === 1'b1) n_bdp++;
      if (busy !== 1'b0) n_busy++;
    end
    chk("midrst_no_start", 64'(n_st), 64'd0);
    chk("midrst_no_batch_done", 64'(n_bdp), 64'd0);
    chk("midrst_stays_idle", 64'(n_busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/puf_challenge_scheduler.md
# puf_challenge_scheduler

Sequencer that drives the FPGA_PUF kernel through a batch of challenges. It accepts one batch command, then for each challenge presents a trigger value and a result address offset and holds them stable for a settle window. It then pulses the kernel start, waits for the kernel done, and advances to the next challenge. It sits between the host-control wrapper logic and the FPGA_PUF instance, replacing the single manual start pulse with an autonomous, timeout-guarded loop.

## Interface
Parameters:
- C_ADDR_WIDTH, 64, width of the result address offset
- C_COUNT_WIDTH, 16, width of challenge count and completed counter
- C_SETTLE_CYCLES, 16, cycles trig/addr are held before each start; legal range 1..255
- C_TIMEOUT_CYCLES, 65535, maximum cycles to wait for done after a start; must be ≥ 1

Ports:
- aclk  in  1  kernel clock; single clock domain
- areset  in  1  reset, synchronous, active-high
- cmd_valid  in  1  batch command valid
- cmd_ready  out  1  high only in IDLE
- cmd_base_trig  in  32  trigger value for the first challenge
- cmd_count  in  C_COUNT_WIDTH  number of challenges; 0 is legal
- cmd_base_addr  in  C_ADDR_WIDTH  result offset for the first challenge
- cmd_addr_stride  in  32  offset increment per challenge, zero-extended
- puf_trig  out  32  trigger to the kernel
- puf_addr_offset  out  C_ADDR_WIDTH  ctrl_addr_offset to the kernel
- puf_start  out  1  single-cycle start pulse to the kernel
- puf_done  in  1  kernel done pulse
- busy  out  1  high whenever state ≠ IDLE
- batch_done  out  1  single-cycle pulse at batch end, including abort
- batch_timeout  out  1  sticky flag; set on timeout, cleared on next command accept
- batch_completed  out  C_COUNT_WIDTH  challenges finished in the current or last batch

## Operation
- The FSM has six states: IDLE, SETTLE, START, WAIT, NEXT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, the command is accepted: latch cmd_count and cmd_addr_stride; load puf_trig=cmd_base_trig and puf_addr_offset=cmd_base_addr; clear batch_completed and batch_timeout.
  - If cmd_count==0, go to DONE; otherwise load the settle counter with C_SETTLE_CYCLES and go to SETTLE.
- SETTLE: decrement the settle counter; when it reads 1, go to START. puf_trig and puf_addr_offset stay stable.
- START: puf_start=1 for this one cycle; load the timeout counter with C_TIMEOUT_CYCLES; go to WAIT.
- WAIT:
  - On puf_done: increment batch_completed. If the new value equals the latched count, go to DONE; otherwise go to NEXT.
  - Else, if the timeout counter reaches 0: set batch_timeout and go to DONE (abort).
  - Else: decrement the timeout counter.
- NEXT:
  - puf_trig += 1, modulo 2^32.
  - puf_addr_offset += stride, modulo 2^C_ADDR_WIDTH.
  - Reload the settle counter and go to SETTLE.
- DONE: batch_done=1 for one cycle; go to IDLE.
- Boundary rules:
  - puf_done is ignored in every state except WAIT.
  - If puf_done and timeout expiry occur in the same cycle, done wins and no timeout is flagged.
  - cmd_valid is ignored while busy; there is no queueing.
  - batch_completed saturates at the latched count and never wraps.
  - puf_trig and puf_addr_offset hold their last values after the batch ends.
  - Reset mid-batch returns to IDLE immediately. No further puf_start is issued, and a pending puf_done after reset is ignored.

## Timing
- Reset values:
  - State is IDLE.
  - cmd_ready=1, busy=0, puf_start=0, batch_done=0, batch_timeout=0.
  - puf_trig=0, puf_addr_offset=0, batch_completed=0.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Command accepted at edge E (cmd_valid & cmd_ready): busy=1 and cmd_ready=0 from cycle E+1.
- First puf_start is high in cycle E+1+S, where S=C_SETTLE_CYCLES.
- puf_done sampled in cycle D (in WAIT):
  - If more challenges remain, the next puf_start is high in cycle D+2+S.
  - If it was the last challenge, batch_done is high in cycle D+1 and state is IDLE at D+2.
- Timeout: with no done, batch_done is high T+2 cycles after the puf_start cycle, where T=C_TIMEOUT_CYCLES.
- cmd_count==0: batch_done is high in cycle E+1; puf_start is never asserted.
- Throughput with immediate done: one challenge per S+3 cycles.

## Test plan
- Reset values: assert areset for 3 cycles -> all outputs at their reset values; cmd_ready=1.
- Nominal batch, S=4: base_trig=0x10, count=3, base_addr=0x1000, stride=0x40, kernel done 5 cycles after each start:
  - exactly 3 puf_start pulses, with trig 0x10/0x11/0x12 and offsets 0x1000/0x1040/0x1080;
  - batch_completed=3, a single batch_done pulse, batch_timeout=0.
- Zero count: count=0 -> batch_done in the cycle after accept, no puf_start, batch_completed=0.
- Timeout, C_TIMEOUT_CYCLES=8: count=4, kernel answers only the first start:
  - batch_timeout=1, batch_completed=1, batch_done 10 cycles after the second puf_start;
  - next command accept clears batch_timeout.
- Wrap and priority: base_trig=0xFFFFFFFF, base_addr=2^64−0x40, stride=0x40, count=2 -> second challenge has trig=0 and offset=0. puf_done coincident with the final timeout cycle -> counted, no timeout flag.
- Reset and spurious inputs: areset asserted in WAIT mid-batch -> IDLE next cycle and no further puf_start. A puf_done pulse or cmd_valid while busy has no effect.
